run_record_builder: RTL and testbench
=====================================

Name: run_record_builder

Overview:
- Downstream consumer of the serial 000/111 triple-run detector.
- Samples the same serial bit stream and the detector's `det` flag on every clock.
- Tracks the current run of identical bits and qualifies a run once `det` is seen.
- When a qualified run ends, emits one record {run bit, run length} over a valid/ready interface to the event logger.

Parameters:
- LEN_W, 8: width of the run-length field; the length saturates at 2^LEN_W-1.
- MIN_RUN, 3: minimum run length the detector flags; used only by the consistency check.
- DROP_W, 8: width of the saturating dropped-record counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial data bit, one sample per clock; the same stream the detector sees.
- det  input  1  detector output; high at edge k means the samples at edges k-3..k-1 were equal.
- rec_valid  output  1  record available.
- rec_ready  input  1  consumer accepts the record when rec_valid && rec_ready at a rising edge.
- rec_bit  output  1  polarity of the finished run.
- rec_len  output  LEN_W  length of the finished run, saturated.
- drop_cnt  output  DROP_W  records lost because the output register was full; saturating.
- chk_err  output  1  sticky consistency error; present only with the optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - state=S_EMPTY, run_bit=0, run_len=0.
  - rec_valid=0, rec_bit=0, rec_len=0, drop_cnt=0, chk_err=0.
  - Reset mid-run discards the partial run and any held record.
- Run tracker (registered):
  - S_EMPTY: the first sample loads run_bit=in, run_len=1, then go to S_TRACK.
  - Other states, in==run_bit: run_len+1, saturating at all-ones.
  - Other states, in!=run_bit: the run closes; reload run_bit=in, run_len=1.
- FSM states: S_EMPTY, S_TRACK (run open, not qualified), S_QUAL (run open, qualified).
  - S_TRACK, det=1, no close this edge: go to S_QUAL.
  - S_TRACK, run closes: stay in S_TRACK, no record.
  - S_QUAL, run closes: emit a record, go to S_TRACK.
  - S_QUAL otherwise: hold.
  - det at the same edge as a close, in S_TRACK: qualifies the closing run. Emit its record and go to S_TRACK.
  - det is ignored in S_EMPTY.
- Emission (one-deep output register):
  - The record carries the pre-update run_bit/run_len, i.e. the run being closed.
  - Latency: rec_valid rises at the edge that samples the first differing bit.
  - Register empty, or emptied this edge (rec_valid && rec_ready): load the record, rec_valid=1.
  - Register full and not accepted this edge: new record dropped, existing record unchanged, drop_cnt+1 saturating.
  - Accept with no new record: rec_valid=0. rec_bit/rec_len hold their last values.
- Outputs are stable while rec_valid && !rec_ready.
- The final open run is never emitted; there is no flush.

Optional Feature:
- Macro RUN_RECORD_CHECK_EN.
- Defined: at any edge with det=1 and state!=S_EMPTY:
  - chk_err sets if the registered run_len < MIN_RUN (detector/tracker misalignment).
  - chk_err is sticky until reset.
- Undefined: the chk_err port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package run_pkg holds:
  - state enum {S_EMPTY, S_TRACK, S_QUAL}.
  - record struct {bit, len[LEN_W-1:0]}.
  - LEN_W/MIN_RUN defaults.
- One sub-module, rec_out_reg: the one-deep valid/ready holding register with drop counting.

Test Plan:
- Stream 0,1,1,1,1,0 with det from a reference detector, rec_ready=1:
  - one record, rec_bit=1, rec_len=4.
  - rec_valid high for exactly one cycle, after the edge sampling the final 0.
- Stream 1,1,0,0,0,0,0,1: one record {0,5}. The leading run of two 1s gives no record.
- rec_ready=0 with two qualified runs 111 then 000 followed by 1:
  - first record {1,3} is held stable.
  - second record dropped, drop_cnt=1.
  - raising rec_ready then clears rec_valid.
- 300 consecutive 1s then a 0, LEN_W=8: record {1,255}.
- Reset asserted mid-run after 1,1,1,1, then stream 0,0,0,1:
  - no record for the 1-run.
  - one record {0,3}.
  - drop_cnt=0.
- With RUN_RECORD_CHECK_EN: force det=1 after only 1,0 → chk_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/run_pkg.sv
// Shared types and default sizes for the run record builder and its output register.
package run_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int MIN_RUN_DEF = 3;
    localparam int DROP_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_TRACK = 2'd1,
        S_QUAL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 run_bit;
        logic [LEN_W_DEF-1:0] len;
    } rec_t;

endpackage

// File: rtl/rec_out_reg.sv
// One-deep valid/ready holding register for finished-run records; counts records
// that arrive while the register is occupied and not being drained.
module rec_out_reg #(
    parameter int LEN_W  = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_bit,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              rec_ready,
    output logic              rec_valid,
    output logic              rec_bit,
    output logic [LEN_W-1:0]  rec_len,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              valid_q, valid_d;
    logic              bit_q, bit_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              accept;

    // Next-state for the holding register and the drop counter.
    always_comb begin
        accept  = valid_q && rec_ready;
        valid_d = valid_q;
        bit_d   = bit_q;
        len_d   = len_q;
        drop_d  = drop_q;
        if (load) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                bit_d   = load_bit;
                len_d   = load_len;
            end else begin
                drop_d = (drop_q == {DROP_W{1'b1}}) ? drop_q : drop_q + DROP_W'(1);
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            len_q   <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
        end
    end

    assign rec_valid = valid_q;
    assign rec_bit   = bit_q;
    assign rec_len   = len_q;
    assign drop_cnt  = drop_q;

endmodule

// File: rtl/run_record_builder.sv
// Tracks runs of identical bits, qualifies them with the detector flag and emits
// {bit, length} records. Optional RUN_RECORD_CHECK_EN adds the sticky chk_err port.
module run_record_builder
    import run_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int DROP_W  = DROP_W_DEF
`ifdef RUN_RECORD_CHECK_EN
    ,
    parameter int MIN_RUN = MIN_RUN_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              det,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_bit,
    output logic [LEN_W-1:0]  rec_len,
    output logic [DROP_W-1:0] drop_cnt
`ifdef RUN_RECORD_CHECK_EN
    ,
    output logic              chk_err
`endif
);

    state_t           state_q, state_d;
    logic             run_bit_q, run_bit_d;
    logic [LEN_W-1:0] run_len_q, run_len_d;
    logic             rec_load;

    // Run tracker and qualification FSM; a record leaves with the run being closed.
    always_comb begin
        state_d   = state_q;
        run_bit_d = run_bit_q;
        run_len_d = run_len_q;
        rec_load  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                run_bit_d = in;
                run_len_d = LEN_W'(1);
                state_d   = S_TRACK;
            end
            S_TRACK, S_QUAL: begin
                if (in != run_bit_q) begin
                    rec_load  = (state_q == S_QUAL) || det;
                    run_bit_d = in;
                    run_len_d = LEN_W'(1);
                    state_d   = S_TRACK;
                end else begin
                    run_len_d = (run_len_q == {LEN_W{1'b1}}) ? run_len_q
                                                             : run_len_q + LEN_W'(1);
                    state_d   = det ? S_QUAL : state_q;
                end
            end
            default: begin
                run_bit_d = 1'b0;
                run_len_d = '0;
                state_d   = S_EMPTY;
            end
        endcase
    end

    // Tracker state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_EMPTY;
            run_bit_q <= 1'b0;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            run_bit_q <= run_bit_d;
            run_len_q <= run_len_d;
        end
    end

    rec_out_reg #(
        .LEN_W  (LEN_W),
        .DROP_W (DROP_W)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (rec_load),
        .load_bit  (run_bit_q),
        .load_len  (run_len_q),
        .rec_ready (rec_ready),
        .rec_valid (rec_valid),
        .rec_bit   (rec_bit),
        .rec_len   (rec_len),
        .drop_cnt  (drop_cnt)
    );

`ifdef RUN_RECORD_CHECK_EN
    logic chk_err_q, chk_err_d;

    // A detector hit on a run shorter than MIN_RUN means the two views disagree.
    always_comb begin
        if (det && (state_q != S_EMPTY) && (run_len_q < LEN_W'(MIN_RUN))) begin
            chk_err_d = 1'b1;
        end else begin
            chk_err_d = chk_err_q;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_run_record_builder.sv
// Randomized and directed scoreboard bench for run_record_builder.
module tb_run_record_builder;
    import run_pkg::*;

    localparam int MAXLEN = (1 << LEN_W_DEF) - 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_s = 1'b0;
    logic                  det_s = 1'b0;
    logic                  rec_ready = 1'b1;
    logic                  rec_valid;
    logic                  rec_bit;
    logic [LEN_W_DEF-1:0]  rec_len;
    logic [DROP_W_DEF-1:0] drop_cnt;
`ifdef RUN_RECORD_CHECK_EN
    logic                  chk_err;
`endif

    run_record_builder dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_s),
        .det       (det_s),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_bit   (rec_bit),
        .rec_len   (rec_len),
        .drop_cnt  (drop_cnt)
`ifdef RUN_RECORD_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];
    rec_t last_rec;
    int   n_pop = 0;

    // Reference model state: the currently open run and the output register.
    bit   mopen, mbit, mqual, mvalid, mchk;
    int   mlen, mdrop;
    bit   hist[$];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input bit b, input bit d, input bit r);
        bit   acc, emit;
        rec_t rr;
        in_s = b; det_s = d; rec_ready = r;
        @(posedge clk);
        acc  = mvalid && r;
        emit = 1'b0;
        rr   = '0;
`ifdef RUN_RECORD_CHECK_EN
        if (mopen && d && mlen < MIN_RUN_DEF) mchk = 1'b1;
`endif
        if (!mopen) begin
            mopen = 1'b1; mbit = b; mlen = 1; mqual = 1'b0;
        end else if (b != mbit) begin
            emit = mqual || d;
            rr.run_bit = mbit;
            rr.len = LEN_W_DEF'(mlen);
            mbit = b; mlen = 1; mqual = 1'b0;
        end else begin
            if (mlen < MAXLEN) mlen++;
            if (d) mqual = 1'b1;
        end
        if (emit) begin
            if (!mvalid || acc) begin
                exp_q.push_back(rr);
                mvalid = 1'b1;
            end else if (mdrop < 255) begin
                mdrop++;
            end
        end else if (acc) begin
            mvalid = 1'b0;
        end
        #1;
        chk("rec_valid", int'(rec_valid), int'(mvalid));
        chk("drop_cnt", int'(drop_cnt), mdrop);
`ifdef RUN_RECORD_CHECK_EN
        chk("chk_err", int'(chk_err), int'(mchk));
`endif
    endtask

    // Drive one sample with det from an ideal 3-sample detector, optionally forced high.
    task automatic send(input bit b, input bit r, input bit force_det);
        bit d;
        d = (hist.size() == 3 && hist[0] == hist[1] && hist[1] == hist[2]) || force_det;
        step(b, d, r);
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic do_reset;
        reset = 1'b1; in_s = 1'b0; det_s = 1'b0; rec_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mopen = 1'b0; mbit = 1'b0; mqual = 1'b0; mvalid = 1'b0; mchk = 1'b0;
        mlen = 0; mdrop = 0;
        exp_q.delete();
        hist.delete();
        chk("reset_valid", int'(rec_valid), 0);
        chk("reset_bit", int'(rec_bit), 0);
        chk("reset_len", int'(rec_len), 0);
        chk("reset_drop", int'(drop_cnt), 0);
`ifdef RUN_RECORD_CHECK_EN
        chk("reset_chk_err", int'(chk_err), 0);
`endif
    endtask

    task automatic send_seq(input bit bits[], input bit r);
        foreach (bits[i]) send(bits[i], r, 1'b0);
    endtask

    task automatic expect_one(input string name, input int base, input bit b, input int len);
        chk({name, "_count"}, n_pop - base, 1);
        chk({name, "_bit"}, int'(last_rec.run_bit), int'(b));
        chk({name, "_len"}, int'(last_rec.len), len);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks holds under backpressure.
    initial begin
        bit   hold;
        rec_t held;
        rec_t e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (hold && !reset) begin
                chk("hold_valid", int'(rec_valid), 1);
                chk("hold_bit", int'(rec_bit), int'(held.run_bit));
                chk("hold_len", int'(rec_len), int'(held.len));
            end
            hold = 1'b0;
            if (!reset && rec_valid) begin
                if (rec_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_record actual=%0d/%0d required=none",
                                 rec_bit, rec_len);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_bit", int'(rec_bit), int'(e.run_bit));
                        chk("rec_len", int'(rec_len), int'(e.len));
                    end
                    last_rec.run_bit = rec_bit;
                    last_rec.len     = rec_len;
                    n_pop++;
                end else begin
                    hold = 1'b1;
                    held.run_bit = rec_bit;
                    held.len     = rec_len;
                end
            end
        end
    end

    initial begin
        int  base;
        bit  prev, b, r, f;
        repeat (2) @(posedge clk);
        #1;

        // Stream 0,1,1,1,1,0 gives a single {1,4}.
        do_reset;
        base = n_pop;
        send_seq('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        expect_one("t1", base, 1'b1, 4);

        // Stream 1,1,0,0,0,0,0,1 gives a single {0,5}.
        do_reset;
        base = n_pop;
        send_seq('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        expect_one("t2", base, 1'b0, 5);

        // Backpressure: first record held, second dropped.
        do_reset;
        base = n_pop;
        send_seq('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0);
        chk("t3_held_bit", int'(rec_bit), 1);
        chk("t3_held_len", int'(rec_len), 3);
        chk("t3_drop", int'(drop_cnt), 1);
        send(1'b1, 1'b1, 1'b0);
        chk("t3_cleared", int'(rec_valid), 0);
        send(1'b1, 1'b1, 1'b0);
        expect_one("t3", base, 1'b1, 3);

        // Length saturation.
        do_reset;
        base = n_pop;
        repeat (300) send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        expect_one("t4", base, 1'b1, MAXLEN);

        // Reset mid-run discards the partial run.
        do_reset;
        base = n_pop;
        send_seq('{1'b1, 1'b1, 1'b1, 1'b1}, 1'b1);
        do_reset;
        send_seq('{1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        expect_one("t5", base, 1'b0, 3);
        chk("t5_drop", int'(drop_cnt), 0);

`ifdef RUN_RECORD_CHECK_EN
        // Forced det on a 1-long run sets the sticky error.
        do_reset;
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        chk("t6_chk_set", int'(chk_err), 1);
        repeat (5) send(1'b0, 1'b1, 1'b0);
        chk("t6_chk_sticky", int'(chk_err), 1);
`endif

        // Randomized segments with backpressure, spurious det and occasional reset.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset;
            prev = 1'($urandom_range(0, 1));
            for (int i = 0; i < 400; i++) begin
                b = ($urandom_range(0, 3) == 0) ? ~prev : prev;
                if ($urandom_range(0, 63) == 0) begin
                    repeat ($urandom_range(260, 300)) send(prev, 1'b1, 1'b0);
                end
                r = ($urandom_range(0, 3) != 0);
                f = ($urandom_range(0, 31) == 0);
                send(b, r, f);
                prev = b;
            end
            repeat (3) send(prev, 1'b1, 1'b0);
            chk("drain_empty", exp_q.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
